audio_irq_ctrl: RTL
===================

# audio_irq_ctrl

Interrupt controller for the audio SoC core. It latches up to eight peripheral interrupt lines (I2S FIFO, DMA done, timer, ...) and applies per-source enables and a global enable. It picks one source by fixed priority and drives the single-cycle `irq` request into the program counter, which redirects to the fixed vector 0x20. It then holds the taken source "in service" until the core signals `mret`; there is no nesting.

## Interface
Parameters:
- `NUM_SRC`, default 4: number of interrupt sources. Legal range 1..8. Source 0 has the highest priority.

Ports:
- `clk`, input, 1: core clock. All logic is on the rising edge.
- `rst`, input, 1: reset. One clock; reset is asynchronous and active-high.
- `src_i`, input, NUM_SRC: raw interrupt lines, synchronous to `clk`.
- `edge_sel`, input, NUM_SRC: per-source mode. 1 = rising-edge, 0 = level-high.
- `en`, input, NUM_SRC: per-source enable mask.
- `glb_en`, input, 1: global interrupt enable.
- `mret`, input, 1: one-cycle pulse when the core retires a return-from-interrupt.
- `clr_valid`, input, 1: software clear strobe for one edge-pending bit.
- `clr_id`, input, 3: index of the bit to clear. Values ≥ NUM_SRC are ignored.
- `irq`, output, 1: one-cycle interrupt request to the pc.
- `irq_id`, output, 3: index of the taken source. Stable from the FIRE cycle until return to IDLE.
- `in_service`, output, 1: high while in the FIRE or SERVICE state.
- `pending`, output, NUM_SRC: registered pending vector.

## Operation
- **Source sampling**
  - `src_q` is a registered copy of `src_i`; it resets to 0.
  - Edge source k: `pending[k]` sets when `src_i[k] & ~src_q[k]`. It clears on a FIRE of source k, or on `clr_valid` with `clr_id==k`.
  - If set and clear occur in the same cycle, set wins.
  - Level source k: `pending[k]` <= `src_i[k]` every cycle. The controller never clears it.
- **Selection**
  - `req = pending & en`.
  - The winner is the lowest index with `req` set.
- **FSM**, 3 states:
  - IDLE:
    - If `glb_en && |req`, go to FIRE and register the winner into `irq_id`.
    - Otherwise stay in IDLE.
  - FIRE:
    - `irq`=1 for exactly this cycle.
    - If the source is edge-mode, clear its pending bit.
    - Unconditionally go to SERVICE.
    - Deasserting `glb_en` or `en` during FIRE does not cancel the request; it is committed.
  - SERVICE:
    - `irq`=0.
    - Wait for `mret`, then go to IDLE.
    - New pending events during SERVICE are latched but not taken; there is no preemption.
- `mret` in IDLE or FIRE is ignored.
- `in_service` = (state != IDLE).
- `irq_id` holds its value after returning to IDLE until the next FIRE.
- **Level-source handler contract:** software must deassert the source before `mret`. Otherwise the same source re-fires after the return.
- Changing `edge_sel[k]` takes effect the next cycle. The existing `pending[k]` value is retained.
- **Reset**, at any time including mid-SERVICE:
  - state = IDLE.
  - `pending`, `src_q`, `irq`, `irq_id`, `in_service` all 0.
- A source already high on the first cycle after reset counts as a rising edge, because `src_q` resets to 0.

## Timing
- **Edge-source latency**, edges E0, E1, E2:
  - Rising `src_i` sampled at E0: `pending` = 1 after E0.
  - After E1: state = FIRE, `irq` = 1.
  - After E2: state = SERVICE, `irq` = 0.
  - `src_i` to `irq` is 2 cycles.
- **Level-source latency:** the same 2 cycles from the first sampled high.
- **Return gap:** `mret` sampled at edge Ek gives IDLE after Ek. The earliest next `irq` is after Ek+1, so there is a minimum 1-cycle gap between service periods.
- **Enable timing:** `glb_en`/`en` are sampled only in IDLE, with no delay beyond the selection register.
- **Strobes:** `irq` is never high in two consecutive cycles. `clr_valid` takes effect at the next edge.

## Test plan
- **Single edge source:** NUM_SRC=4, en=4'b1111, glb_en=1, src_i[2] 0→1 at cycle 10.
  - Expect `irq`=1 only at cycle 12 with `irq_id`=2.
  - Expect `pending[2]` back to 0 at cycle 13 and `in_service`=1.
  - Pulse `mret` at 20: `in_service`=0 at 21 and no re-fire.
- **Priority:** src_i[3] and src_i[1] rise in the same cycle.
  - First `irq_id`=1.
  - After `mret`, second `irq_id`=3 exactly 2 cycles after the `mret` edge.
- **Masking:** en[0]=0, source 0 edge → `pending[0]`=1 and no `irq`.
  - Set en[0]=1 later → `irq` one cycle after en rises, `irq_id`=0.
  - Repeat with glb_en=0 → no `irq` until glb_en=1.
- **Level re-fire:** edge_sel[1]=0, src_i[1] held high through `mret` → a second `irq` with `irq_id`=1 2 cycles after `mret`.
  - Drop src_i[1] before `mret` → no second `irq`.
- **Set/clear collision and software clear:**
  - clr_valid=1, clr_id=0 in the same cycle as a source-0 rising edge → `pending[0]`=1.
  - clr_id=0 alone while masked → `pending[0]`=0.
  - clr_id=6 with NUM_SRC=4 → no change.
- **Reset mid-service:** assert `rst` asynchronously during SERVICE.
  - All outputs 0 immediately.
  - With src_i[0] high at release → `irq` 2 cycles after the first post-reset edge, `irq_id`=0.

Source files
------------

// File: rtl/audio_irq_ctrl.sv
// audio_irq_ctrl: latches up to eight peripheral interrupt lines, masks them,
// picks one by fixed priority (source 0 highest) and issues a single-cycle
// irq. The taken source stays in service until the core retires mret; there
// is no nesting or preemption.
module audio_irq_ctrl #(
  parameter int NUM_SRC = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_SRC-1:0] src_i,
  input  logic [NUM_SRC-1:0] edge_sel,
  input  logic [NUM_SRC-1:0] en,
  input  logic               glb_en,
  input  logic               mret,
  input  logic               clr_valid,
  input  logic [2:0]         clr_id,
  output logic               irq,
  output logic [2:0]         irq_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRE    = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t             state;
  logic [NUM_SRC-1:0] src_q;
  logic [NUM_SRC-1:0] req;
  logic [2:0]         winner;

  // Previous-cycle copy of the raw lines for rising-edge detection. Resetting
  // to 0 makes a line already high after reset look like a fresh edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= '0;
    end else begin
      src_q <= src_i;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_pend
      logic rise;
      logic clr;

      assign rise = src_i[gi] & ~src_q[gi];
      // A software clear for an index >= NUM_SRC never matches any bit here,
      // so out-of-range clr_id values are ignored naturally.
      assign clr  = (clr_valid && (clr_id == 3'(gi))) ||
                    ((state == FIRE) && (irq_id == 3'(gi)));

      // Edge sources latch rises and drop on clear (set wins a collision);
      // level sources simply follow the raw line.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          pending[gi] <= 1'b0;
        end else if (edge_sel[gi]) begin
          pending[gi] <= rise | (pending[gi] & ~clr);
        end else begin
          pending[gi] <= src_i[gi];
        end
      end
    end
  endgenerate

  assign req = pending & en;

  // Fixed priority: the lowest requesting index wins.
  always_comb begin
    winner = 3'd0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner = 3'(i);
      end
    end
  end

  // Request sequencer: IDLE -> FIRE (one-cycle irq) -> SERVICE until mret.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      irq    <= 1'b0;
      irq_id <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          if (glb_en && (|req)) begin
            state  <= FIRE;
            irq    <= 1'b1;
            irq_id <= winner;
          end else begin
            irq    <= 1'b0;
          end
        end
        FIRE: begin
          // Committed: enables are not re-checked here.
          irq   <= 1'b0;
          state <= SERVICE;
        end
        SERVICE: begin
          irq <= 1'b0;
          if (mret) begin
            state <= IDLE;
          end
        end
        default: begin
          irq   <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_service = (state != IDLE);

endmodule
